// File: rtl/jk_cnt_pkg.sv
// Shared types and constants for the JK-flip-flop counter controller:
// the controller FSM states and the two-bit {J,K} drive codes.
package jk_cnt_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // {J,K} codes presented to one JK cell.
  localparam logic [1:0] HOLD   = 2'b00;
  localparam logic [1:0] RESET  = 2'b01;
  localparam logic [1:0] SET    = 2'b10;
  localparam logic [1:0] TOGGLE = 2'b11;

endpackage

// File: rtl/jk_ff_cell.sv
// Single JK flip-flop with asynchronous active-low clear; exposes Q and Q-not.
module jk_ff_cell
  import jk_cnt_pkg::*;
(
  input  logic clk,
  input  logic clr_n,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qn
);

  logic q_q;

  // NOTE: sequential state is written only with non-blocking assignments so every
  // flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q_q <= 1'b0;
    end else begin
      case ({j, k})
        HOLD:    q_q <= q_q;
        RESET:   q_q <= 1'b0;
        SET:     q_q <= 1'b1;
        TOGGLE:  q_q <= ~q_q;
        default: q_q <= q_q;
      endcase
    end
  end

  assign q  = q_q;
  assign qn = ~q_q;

endmodule

// File: rtl/jk_counter_ctrl.sv
// Modulo-MOD up/down counter built from a bank of JK cells, with run/idle FSM
// and a parallel-load handshake. Define JK_CNT_AUTOSTOP_EN to stop on wrap.
module jk_counter_ctrl
  import jk_cnt_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

  state_e           state_q;
  logic             busy_q;
  logic             tc_q;
  logic             load_err_q;

  logic [WIDTH-1:0] q_bits;
  logic [WIDTH-1:0] qn_bits;
  logic [WIDTH-1:0] t_d;
  logic [WIDTH-1:0] j_bits;
  logic [WIDTH-1:0] k_bits;
  logic             tc_d;
  logic             load_err_d;
  logic             load_fire;
  logic             stop_on_wrap;

  // NOTE: the load window is exactly "not in reset", so it follows reset_n
  // combinationally instead of waiting one edge after release.
  assign load_ready = reset_n;
  assign load_fire  = load_valid & load_ready;

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    t_d        = q_bits;
    tc_d       = 1'b0;
    load_err_d = 1'b0;
    if (load_fire) begin
      if ({1'b0, load_data} >= MOD_EXT) begin
        t_d        = '0;
        load_err_d = 1'b1;
      end else begin
        t_d = load_data;
      end
    end else if (state_q == RUN && !stop) begin
      if (dir) begin
        tc_d = (q_bits == MAX_VAL);
        t_d  = tc_d ? '0 : q_bits + WIDTH'(1);
      end else begin
        tc_d = (q_bits == '0);
        t_d  = tc_d ? MAX_VAL : q_bits - WIDTH'(1);
      end
    end
  end

`ifdef JK_CNT_AUTOSTOP_EN
  assign stop_on_wrap = tc_d;
`else
  assign stop_on_wrap = 1'b0;
`endif

  // Toggle-minimal drive: set bits that must rise, reset bits that must fall.
  assign j_bits = t_d & qn_bits;
  assign k_bits = ~t_d & q_bits;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_ff_cell u_cell (
      .clk   (clk),
      .clr_n (reset_n),
      .j     (j_bits[i]),
      .k     (k_bits[i]),
      .q     (q_bits[i]),
      .qn    (qn_bits[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      tc_q       <= tc_d;
      load_err_q <= load_err_d;
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (stop || stop_on_wrap) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign q        = q_bits;
  assign tc       = tc_q;
  assign busy     = busy_q;
  assign load_err = load_err_q;

endmodule
